// File: rtl/count_seq_monitor.sv
// count_seq_monitor: checks that a sampled count bus advances by exactly +1
// (mod 2^WIDTH) per sample, declares lock after LOCK_COUNT consecutive legal
// steps, and keeps saturating statistics of sequence errors and wraps.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   q_in         count value from the upstream counter
//   en           sample strobe; q_in is evaluated only when en=1
//   clear_stats  synchronous clear of err_count / wrap_count
//   locked       high while in LOCKED
//   seq_err      one-cycle pulse when a locked sample breaks the sequence
//   wrap_pulse   one-cycle pulse on a locked max->0 step
//   err_count    saturating count of seq_err events
//   wrap_count   saturating count of wrap_pulse events
//
// Optional build macro COUNT_SEQ_MONITOR_SYNC_EN: inserts a two-flop
// synchronizer on q_in (and a matching two-stage delay on en), adding two
// cycles of latency to every response.
//
// state  | meaning
// IDLE   | no reference sample yet; next sample only seeds prev
// VERIFY | counting consecutive legal +1 steps toward lock
// LOCKED | sequence trusted; breaks are reported as seq_err

module count_seq_monitor #(
  parameter int WIDTH      = 3,
  parameter int LOCK_COUNT = 2,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     q_in,
  input  logic                 en,
  input  logic                 clear_stats,
  output logic                 locked,
  output logic                 seq_err,
  output logic                 wrap_pulse,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [ERR_CNT_W-1:0] wrap_count
);

  typedef enum logic [1:0] {IDLE, VERIFY, LOCKED} state_e;

  localparam logic [WIDTH-1:0]     Q_MAX    = '1;
  localparam logic [ERR_CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [3:0]           LOCK_TGT = 4'(LOCK_COUNT);

  logic [WIDTH-1:0] q_smp;
  logic             en_smp;

`ifdef COUNT_SEQ_MONITOR_SYNC_EN
  logic [WIDTH-1:0] q_s1_q, q_s2_q;
  logic             en_s1_q, en_s2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      q_s1_q  <= '0;
      q_s2_q  <= '0;
      en_s1_q <= 1'b0;
      en_s2_q <= 1'b0;
    end else begin
      q_s1_q  <= q_in;
      q_s2_q  <= q_s1_q;
      en_s1_q <= en;
      en_s2_q <= en_s1_q;
    end
  end

  assign q_smp  = q_s2_q;
  assign en_smp = en_s2_q;
`else
  assign q_smp  = q_in;
  assign en_smp = en;
`endif

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     prev_q, prev_d;
  logic [3:0]           good_q, good_d;
  logic                 locked_q, seq_err_q, wrap_q;
  logic                 seq_err_d, wrap_d;
  logic [ERR_CNT_W-1:0] err_q, err_d, wcnt_q, wcnt_d;

  logic [WIDTH-1:0] prev_inc;
  logic [3:0]       good_inc;
  logic             is_step, is_hold;

  assign prev_inc = prev_q + 1'b1;   // wraps naturally at 2^WIDTH
  assign good_inc = good_q + 4'd1;
  assign is_step  = (q_smp == prev_inc);
  assign is_hold  = (q_smp == prev_q);

  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    good_d    = good_q;
    seq_err_d = 1'b0;
    wrap_d    = 1'b0;

    if (en_smp) begin
      prev_d = q_smp;
      unique case (state_q)
        IDLE: begin
          good_d  = '0;
          state_d = VERIFY;
        end
        VERIFY: begin
          if (is_step) begin
            if (good_inc == LOCK_TGT) begin
              good_d  = '0;
              state_d = LOCKED;
            end else begin
              good_d = good_inc;
            end
          end else if (!is_hold) begin
            good_d = '0;
          end
        end
        LOCKED: begin
          if (is_step) begin
            // A BAD sample of 0 never reaches here, so it cannot wrap.
            wrap_d = (prev_q == Q_MAX);
          end else if (!is_hold) begin
            seq_err_d = 1'b1;
            good_d    = '0;
            state_d   = VERIFY;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Clear and a same-edge event: counted from zero, so the result is 1.
    if (clear_stats)
      err_d = {{(ERR_CNT_W-1){1'b0}}, seq_err_d};
    else if (seq_err_d && (err_q != CNT_MAX))
      err_d = err_q + 1'b1;
    else
      err_d = err_q;

    if (clear_stats)
      wcnt_d = {{(ERR_CNT_W-1){1'b0}}, wrap_d};
    else if (wrap_d && (wcnt_q != CNT_MAX))
      wcnt_d = wcnt_q + 1'b1;
    else
      wcnt_d = wcnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      prev_q    <= '0;
      good_q    <= '0;
      locked_q  <= 1'b0;
      seq_err_q <= 1'b0;
      wrap_q    <= 1'b0;
      err_q     <= '0;
      wcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      good_q    <= good_d;
      locked_q  <= (state_d == LOCKED);
      seq_err_q <= seq_err_d;
      wrap_q    <= wrap_d;
      err_q     <= err_d;
      wcnt_q    <= wcnt_d;
    end
  end

  assign locked     = locked_q;
  assign seq_err    = seq_err_q;
  assign wrap_pulse = wrap_q;
  assign err_count  = err_q;
  assign wrap_count = wcnt_q;

endmodule

// File: tb/tb_count_seq_monitor.sv
module tb_count_seq_monitor;

`ifdef COUNT_SEQ_MONITOR_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] q_in = 3'd0;
  logic       en = 1'b0;
  logic       clear_stats = 1'b0;

  logic       lk8, se8, wp8, lk2, se2, wp2;
  logic [7:0] ec8, wc8;
  logic [1:0] ec2, wc2;

  always #5 clk = ~clk;

  count_seq_monitor #(.WIDTH(3), .LOCK_COUNT(2), .ERR_CNT_W(8)) dut (
    .clk(clk), .reset(reset), .q_in(q_in), .en(en), .clear_stats(clear_stats),
    .locked(lk8), .seq_err(se8), .wrap_pulse(wp8),
    .err_count(ec8), .wrap_count(wc8));

  count_seq_monitor #(.WIDTH(3), .LOCK_COUNT(2), .ERR_CNT_W(2)) dut_s (
    .clk(clk), .reset(reset), .q_in(q_in), .en(en), .clear_stats(clear_stats),
    .locked(lk2), .seq_err(se2), .wrap_pulse(wp2),
    .err_count(ec2), .wrap_count(wc2));

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input int exp);
    vectors++;
    if (act !== 32'(exp)) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 = no reference yet, 1 = building trust, 2 = trusted.
  int m_phase, m_prev, m_good, m_lock, m_err_p, m_wrap_p;
  int m_ec8, m_wc8, m_ec2, m_wc2;
  int pq[2];
  int pe[2];

  function automatic int bump(input int c, input bit ev, input bit clr, input int maxv);
    if (clr) return ev ? 1 : 0;
    if (ev && c < maxv) return c + 1;
    return c;
  endfunction

  always @(posedge clk) begin
    int sq, se;
    bit ev_e, ev_w;
    if (reset) begin
      m_phase = 0; m_prev = 0; m_good = 0; m_lock = 0;
      m_err_p = 0; m_wrap_p = 0;
      m_ec8 = 0; m_wc8 = 0; m_ec2 = 0; m_wc2 = 0;
      pq[0] = 0; pq[1] = 0; pe[0] = 0; pe[1] = 0;
    end else begin
      if (LAT == 0) begin
        sq = int'(q_in); se = int'(en);
      end else begin
        sq = pq[1]; se = pe[1];
        pq[1] = pq[0]; pe[1] = pe[0];
        pq[0] = int'(q_in); pe[0] = int'(en);
      end
      ev_e = 0; ev_w = 0;
      if (se != 0) begin
        if (m_phase == 0) begin
          m_phase = 1; m_good = 0;
        end else if (sq == (m_prev + 1) % 8) begin
          if (m_phase == 1) begin
            m_good = m_good + 1;
            if (m_good == 2) begin m_phase = 2; m_good = 0; end
          end else if (m_prev == 7) begin
            ev_w = 1;
          end
        end else if (sq != m_prev) begin
          if (m_phase == 2) begin ev_e = 1; m_phase = 1; end
          m_good = 0;
        end
        m_prev = sq;
      end
      m_lock   = (m_phase == 2) ? 1 : 0;
      m_err_p  = ev_e;
      m_wrap_p = ev_w;
      m_ec8 = bump(m_ec8, ev_e, clear_stats, 255);
      m_wc8 = bump(m_wc8, ev_w, clear_stats, 255);
      m_ec2 = bump(m_ec2, ev_e, clear_stats, 3);
      m_wc2 = bump(m_wc2, ev_w, clear_stats, 3);
    end
  end

  bit chk_en = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("locked",      lk8, m_lock);
      check("seq_err",     se8, m_err_p);
      check("wrap_pulse",  wp8, m_wrap_p);
      check("err_count",   ec8, m_ec8);
      check("wrap_count",  wc8, m_wc8);
      check("s_locked",    lk2, m_lock);
      check("s_seq_err",   se2, m_err_p);
      check("s_wrap",      wp2, m_wrap_p);
      check("s_err_count", ec2, m_ec2);
      check("s_wrap_count", wc2, m_wc2);
    end
  end

  int cycn = 0;
  int lock_cyc = -1;
  bit lock_seen = 0;
  int cur = 0;

  task automatic cyc(input bit r, input bit e, input int q, input bit c);
    reset = r; en = e; q_in = 3'(q); clear_stats = c;
    @(posedge clk);
    #1;
    cycn++;
    if (!lock_seen && lk8 === 1'b1) begin
      lock_seen = 1;
      lock_cyc = cycn;
    end
  endtask

  task automatic samp(input int q);
    cur = q % 8;
    cyc(0, 1, cur, 0);
  endtask

  task automatic flush();
    repeat (LAT + 1) cyc(0, 0, cur, 0);
  endtask

  task automatic relock();
    samp(cur + 1);
    samp(cur + 1);
  endtask

  initial begin
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk_en = 1;
    check("rst_locked", lk8, 0);
    check("rst_err", ec8, 0);
    check("rst_wrap", wc8, 0);

    cycn = 0; lock_seen = 0;
    samp(0); samp(1); samp(2);
    flush();
    check("lock_latency", lock_cyc, 3 + LAT);
    check("locked_up", lk8, 1);

    samp(3); samp(3); samp(4); samp(5); samp(6); samp(7); samp(0);
    flush();
    check("wrap_once", wc8, 1);
    check("no_err", ec8, 0);

    samp(1); samp(2); samp(5);
    flush();
    check("bad_unlock", lk8, 0);
    check("err_one", ec8, 1);
    samp(6); samp(7);
    flush();
    check("relocked", lk8, 1);

    samp(0); samp(1); samp(2); samp(3);
    samp(0);
    flush();
    check("bad_zero_err", ec8, 2);
    check("bad_zero_nowrap", wc8, 2);
    check("bad_zero_unlock", lk8, 0);
    relock();

    for (int i = 0; i < 5; i++) begin
      samp(cur + 3);
      relock();
    end
    flush();
    check("err_7", ec8, 7);
    check("err_sat", ec2, 3);

    cur = (cur + 3) % 8;
    cyc(0, 1, cur, LAT == 0);
    for (int i = 0; i < LAT; i++) cyc(0, 0, cur, i == LAT - 1);
    flush();
    check("clr_evt_err", ec8, 1);
    check("clr_evt_err_s", ec2, 1);
    check("clr_wrap", wc8, 0);

    relock();
    samp(cur + 3);
    relock();
    for (int i = 0; i < 32; i++) samp(cur + 1);
    flush();
    check("pre_rst_err", ec8, 2);
    check("pre_rst_wrap", wc8, 4);
    check("pre_rst_wrap_s", wc2, 3);
    check("pre_rst_locked", lk8, 1);

    cyc(1, 0, cur, 0);
    check("mid_rst_locked", lk8, 0);
    check("mid_rst_err", ec8, 0);
    check("mid_rst_wrap", wc8, 0);
    check("mid_rst_se", se8, 0);
    check("mid_rst_wp", wp8, 0);

    samp(4); samp(5); samp(6);
    flush();
    check("post_rst_lock", lk8, 1);

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/count_seq_monitor.md
Name: count_seq_monitor

Overview:
- Sits directly downstream of the 3-bit JK up-counter.
- Samples the counter's Q output and checks that it advances by exactly +1 (mod 2^WIDTH) per sample.
- Flags sequence errors, emits a pulse on every legal wrap, and keeps saturating error and wrap statistics for the bench and for later self-check logic.

Parameters:
- WIDTH, 3, width of the monitored count bus.
- LOCK_COUNT, 2, consecutive legal +1 steps required before the monitor declares lock (range 1..15).
- ERR_CNT_W, 8, width of the error and wrap statistic counters.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- q_in  input  WIDTH  count value from the upstream counter.
- en  input  1  sample strobe; q_in is evaluated only on cycles with en=1.
- clear_stats  input  1  synchronous clear of err_count and wrap_count.
- locked  output  1  high while the monitor is in state LOCKED.
- seq_err  output  1  one-cycle pulse when a locked sample breaks the sequence.
- wrap_pulse  output  1  one-cycle pulse when a locked sample goes from max (2^WIDTH-1) to 0.
- err_count  output  ERR_CNT_W  saturating count of seq_err events.
- wrap_count  output  ERR_CNT_W  saturating count of wrap_pulse events.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk, reset).
- Reset, sampled on a rising clk edge:
  - All outputs become 0.
  - State becomes IDLE; prev and good_cnt become 0.
  - Reset overrides every other input.
  - Reset asserted mid-operation clears all state at the next edge, with no seq_err or wrap_pulse generated for that cycle.
- Outputs are all registered. The response to a sample taken at edge N is visible after edge N, for one cycle for the pulses.
- Step classification (en=1 only), with prev being the last sampled value:
  - STEP: q_in == prev+1 mod 2^WIDTH.
  - HOLD: q_in == prev.
  - BAD: anything else.
- State IDLE, on en: prev<=q_in, good_cnt<=0, go VERIFY. No checking on the first sample.
- State VERIFY, on en:
  - STEP: good_cnt++. When the incremented value equals LOCK_COUNT, go LOCKED and good_cnt<=0.
  - HOLD: no change.
  - BAD: good_cnt<=0, stay in VERIFY, no seq_err.
  - prev<=q_in always.
- State LOCKED, on en:
  - STEP: no error. If prev==2^WIDTH-1 and q_in==0, pulse wrap_pulse and increment wrap_count.
  - HOLD: legal; no pulses.
  - BAD: pulse seq_err, increment err_count, go VERIFY with good_cnt<=0; locked falls after the same edge.
  - prev<=q_in always.
- en=0: state, prev, and counters hold; pulses are 0.
- Saturation: err_count and wrap_count stop at 2^ERR_CNT_W-1 and never wrap.
- clear_stats sets both counters to 0. If an increment event occurs on the same edge, the counter becomes 1 (event wins, counted from zero).
- A BAD sample that equals 0 (e.g. prev=3, q_in=0) is an error only; it never produces a wrap_pulse.

Optional Feature:
- Macro COUNT_SEQ_MONITOR_SYNC_EN.
- Defined: q_in passes through a two-flop synchronizer (reset to 0) before classification, for use when the upstream counter is ripple-clocked. en is delayed by the same two stages so samples stay aligned. Every response then appears 2 cycles later than stated above.
- Undefined: q_in is used directly with the latency stated above, and no synchronizer flops exist.

Test Plan:
- Hold reset 2 cycles, then en=1 and q_in counting 0,1,2,… each cycle → with LOCK_COUNT=2, locked=1 after the third sample edge (samples 0→1→2); seq_err stays 0.
- Locked, q_in goes 6,7,0 → wrap_pulse high exactly one cycle after the 7→0 sample; wrap_count=1; seq_err=0.
- Locked at q_in=2, next sample q_in=5 → seq_err pulses once and locked=0 on the same cycle; err_count=1; after samples 6,7 locked=1 again.
- Locked at prev=3, inject q_in=0 → seq_err=1, wrap_pulse=0, err_count increments.
- ERR_CNT_W=2, inject 5 BAD samples, each followed by relock → err_count saturates at 3. Then assert clear_stats on the same edge as a seq_err → err_count=1.
- Assert reset while locked with err_count=2 and wrap_count=4 → next cycle all outputs are 0 and state is IDLE. Repeat with COUNT_SEQ_MONITOR_SYNC_EN defined and confirm lock arrives 2 cycles later than without it.
